// File: rtl/mod255_frame_accumulator.sv
// Per-frame mod-255 residue unit: streams bytes through an end-around-carry
// adder and reports one normalized residue plus beat count per frame.

module P8_node_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] s
);
    logic [7:0] p;
    logic [7:0] g;
    logic [7:0] gg;
    logic [7:0] pp;
    logic [7:0] c;
    logic       cout;

    assign p = a ^ b;
    assign g = a & b;

    // Group generate/propagate; the block carry-out feeds back as carry-in.
    always_comb begin
        gg[0] = g[0];
        pp[0] = p[0];
        for (int i = 1; i < 8; i++) begin
            gg[i] = g[i] | (p[i] & gg[i-1]);
            pp[i] = p[i] & pp[i-1];
        end
    end

    assign cout = gg[7];

    always_comb begin
        c[0] = cout;
        for (int i = 1; i < 8; i++) begin
            c[i] = gg[i-1] | (pp[i-1] & cout);
        end
    end

    assign s = p ^ c;
endmodule

module mod255_frame_accumulator #(
    parameter int COUNT_W   = 16,
    parameter int NORMALIZE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    input  logic               in_abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_sum,
    output logic [COUNT_W-1:0] out_count
);
    typedef enum logic {ACCUM, HOLD} state_e;

    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    state_e             state_q, state_d;
    logic [7:0]         acc_q, acc_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]         out_sum_q, out_sum_d;
    logic [COUNT_W-1:0] out_count_q, out_count_d;
    logic               out_valid_q, out_valid_d;
    logic               live_q;

    logic [7:0]         sum;
    logic [7:0]         sum_norm;
    logic [COUNT_W-1:0] cnt_inc;
    logic               accept;

    P8_node_adder u_adder (
        .a (acc_q),
        .b (in_data),
        .s (sum)
    );

    // live_q keeps in_ready low while reset is asserted.
    assign in_ready  = live_q && (state_q == ACCUM);
    assign accept    = in_valid && in_ready;
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign sum_norm  = ((NORMALIZE != 0) && (sum == 8'hFF)) ? 8'h00 : sum;

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            ACCUM: begin
                if (in_abort) begin
                    acc_d = 8'h00;
                    cnt_d = '0;
                end else if (accept) begin
                    if (in_last) begin
                        out_sum_d   = sum_norm;
                        out_count_d = cnt_inc;
                        out_valid_d = 1'b1;
                        acc_d       = 8'h00;
                        cnt_d       = '0;
                        state_d     = HOLD;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_inc;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= 8'h00;
            cnt_q       <= '0;
            out_sum_q   <= 8'h00;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
            live_q      <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mod255_frame_accumulator.sv
// Directed bench for mod255_frame_accumulator, including NORMALIZE=0
// and COUNT_W=8 variants driven by the same stimulus.

module tb_mod255_frame_accumulator;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_abort;
    logic        out_ready;

    logic        in_ready, in_ready_n0, in_ready_c8;
    logic        out_valid, out_valid_n0, out_valid_c8;
    logic [7:0]  out_sum, out_sum_n0, out_sum_c8;
    logic [15:0] out_count, out_count_n0;
    logic [7:0]  out_count_c8;

    int checks = 0;
    int errors = 0;

    mod255_frame_accumulator #(.COUNT_W(16), .NORMALIZE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_abort(in_abort),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count)
    );

    mod255_frame_accumulator #(.COUNT_W(16), .NORMALIZE(0)) dut_n0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_n0),
        .in_data(in_data), .in_last(in_last), .in_abort(in_abort),
        .out_valid(out_valid_n0), .out_ready(out_ready),
        .out_sum(out_sum_n0), .out_count(out_count_n0)
    );

    mod255_frame_accumulator #(.COUNT_W(8), .NORMALIZE(1)) dut_c8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_c8),
        .in_data(in_data), .in_last(in_last), .in_abort(in_abort),
        .out_valid(out_valid_c8), .out_ready(out_ready),
        .out_sum(out_sum_c8), .out_count(out_count_c8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with in_ready high; returns at the next negedge.
    task automatic beat(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic result(input string tag, input logic [7:0] s,
                          input logic [15:0] n);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_sum"}, {24'd0, out_sum}, {24'd0, s});
        check({tag, "_count"}, {16'd0, out_count}, {16'd0, n});
    endtask

    // With out_ready high: result pops at the next edge, ready follows.
    task automatic pop(input string tag);
        @(negedge clk);
        check({tag, "_pop"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        in_abort  = 1'b0;
        out_ready = 1'b1;

        #3;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {24'd0, out_sum}, 32'd0);
        check("rst_out_count", {16'd0, out_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // Three-beat frame with a stray in_last while idle in between
        beat(8'h10, 1'b0);
        in_last = 1'b1;
        @(negedge clk);
        in_last = 1'b0;
        check("stray_last", {31'd0, out_valid}, 32'd0);
        beat(8'h20, 1'b0);
        beat(8'h30, 1'b1);
        result("f123", 8'h60, 16'd3);
        pop("f123");

        // End-around carry
        beat(8'hFF, 1'b0);
        beat(8'h01, 1'b1);
        result("eac", 8'h01, 16'd2);
        pop("eac");

        // Raw 0xFF: normalized vs raw
        beat(8'h80, 1'b0);
        beat(8'h7F, 1'b1);
        result("norm", 8'h00, 16'd2);
        check("raw_sum", {24'd0, out_sum_n0}, 32'hFF);
        pop("norm");

        // 300 beats of 1; COUNT_W=8 saturates at 255
        for (int i = 0; i < 300; i++) beat(8'h01, i == 299);
        result("long", 8'h2D, 16'd300);
        check("sat_count", {24'd0, out_count_c8}, 32'd255);
        check("sat_sum", {24'd0, out_sum_c8}, 32'h2D);
        pop("long");

        // Backpressure; abort during HOLD must not disturb the result
        out_ready = 1'b0;
        beat(8'hAB, 1'b1);
        for (int i = 0; i < 5; i++) begin
            result($sformatf("hold%0d", i), 8'hAB, 16'd1);
            check($sformatf("hold%0d_ready", i), {31'd0, in_ready}, 32'd0);
            in_abort = (i == 2);
            @(negedge clk);
            in_abort = 1'b0;
        end
        out_ready = 1'b1;
        pop("hold");

        // Abort drops the frame, including the concurrent last beat
        beat(8'h05, 1'b0);
        beat(8'h06, 1'b0);
        in_abort = 1'b1;
        beat(8'h07, 1'b1);
        in_abort = 1'b0;
        check("abort_noresult", {31'd0, out_valid}, 32'd0);
        beat(8'h09, 1'b1);
        result("after_abort", 8'h09, 16'd1);
        pop("after_abort");

        // Asynchronous reset mid-frame
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", {31'd0, in_ready}, 32'd0);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_sum", {24'd0, out_sum}, 32'd0);
        check("arst_out_count", {16'd0, out_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_ready", {31'd0, in_ready}, 32'd1);
        beat(8'h01, 1'b1);
        result("arst_frame", 8'h01, 16'd1);
        pop("arst_frame");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
